mean_restore: RTL and testbench

Re-inserts a DC offset into a zero-mean audio sample stream: adds a registered mean to each incoming signed sample and emits the restored sample with a valid strobe. Sits downstream of the mean-subtraction stage in the I2S → FIFO → ZCR/STE → sub-mean → beamform chain, on the playback/reconstruction path. A new mean is delay-aligned so that it takes effect exactly ALIGN_DELAY samples after it is loaded. This matches the fixed sample skew between the subtractor's window input and output indices.

---
 rtl/mean_restore.sv | 98 +++++++++
 tb/tb_mean_restore.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mean_restore.sv
// mean_restore: re-inserts a delay-aligned DC mean into a zero-mean signed sample stream.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          synchronous, active-high; clears all state
//   data_in        signed zero-mean sample (DATA_WIDTH)
//   data_valid     data_in accepted this cycle
//   mean_in        signed mean to add (DATA_WIDTH)
//   mean_load      capture mean_in this cycle
//   restore_out    registered restored sample, holds when restore_valid is low
//   restore_valid  one-cycle strobe per restored sample
//   sat_flag       sticky overflow indicator (always 0 unless SATURATE_EN)
//   drop_count     samples discarded before the first mean, saturates at 255
//
// Build option: define SATURATE_EN to clamp overflowing sums and drive sat_flag;
// otherwise sums wrap to DATA_WIDTH bits and no clamp logic exists.
module mean_restore #(
   parameter int DATA_WIDTH  = 16,
   parameter int ALIGN_DELAY = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   input  logic [DATA_WIDTH-1:0] mean_in,
   input  logic                  mean_load,
   output logic [DATA_WIDTH-1:0] restore_out,
   output logic                  restore_valid,
   output logic                  sat_flag,
   output logic [7:0]            drop_count
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RUN     = 2'd1;
   localparam logic [1:0] PENDING = 2'd2;
   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] active_mean, pending_mean, use_mean, result;
   logic [7:0]            count;
   logic                  take_pending;
   // Alignment has expired: this sample is the first to see the new mean.
   assign take_pending = (state == PENDING) && (count == 8'd0);
   assign use_mean     = take_pending ? pending_mean : active_mean;
`ifdef SATURATE_EN
   logic [DATA_WIDTH:0] sum;
   logic                ovf;
   assign sum    = {data_in[DATA_WIDTH-1], data_in} + {use_mean[DATA_WIDTH-1], use_mean};
   assign ovf    = sum[DATA_WIDTH] ^ sum[DATA_WIDTH-1];
   // sum[DATA_WIDTH] is the true sign: 0 means positive overflow -> max, 1 -> min.
   assign result = ovf ? {sum[DATA_WIDTH], {(DATA_WIDTH-1){~sum[DATA_WIDTH]}}} : sum[DATA_WIDTH-1:0];
   always_ff @(posedge clk) begin
      if (reset)
         sat_flag <= 1'b0;
      else if (data_valid && state != IDLE && ovf)
         sat_flag <= 1'b1;
   end
`else
   assign result   = data_in + use_mean;
   assign sat_flag = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         active_mean   <= '0;
         pending_mean  <= '0;
         count         <= '0;
         restore_out   <= '0;
         restore_valid <= 1'b0;
         drop_count    <= '0;
      end else begin
         restore_valid <= 1'b0;
         if (data_valid) begin
            if (state == IDLE)
               drop_count <= drop_count + {7'd0, drop_count != 8'hFF};
            else begin
               restore_out   <= result;
               restore_valid <= 1'b1;
            end
         end
         // A same-cycle load wins over alignment: the sample above used the old
         // mean and does not advance the countdown.
         if (mean_load) begin
            if (state == IDLE) begin
               active_mean <= mean_in;
               state       <= RUN;
            end else begin
               pending_mean <= mean_in;
               count        <= 8'(ALIGN_DELAY);
               state        <= PENDING;
            end
         end else if (data_valid && state == PENDING) begin
            if (take_pending) begin
               active_mean <= pending_mean;
               state       <= RUN;
            end else
               count <= count - 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_mean_restore.sv
// tb_mean_restore: randomized scoreboard bench for mean_restore against a behavioural model.
module tb_mean_restore;
   localparam int W  = 16;
   localparam int AD = 7;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] data_in = '0, mean_in = '0;
   logic         data_valid = 1'b0, mean_load = 1'b0;
   logic [W-1:0] restore_out;
   logic         restore_valid, sat_flag;
   logic [7:0]   drop_count;
   int           checks = 0, errors = 0;
   // Behavioural model: whether a mean exists, the mean in force, and an
   // optional future mean with the number of samples still to wait for it.
   bit           have = 0, pv = 0;
   logic [W-1:0] act = '0, pend = '0;
   int           rem = 0;
   int           drops = 0;
   bit           esat = 0, ev = 0;
   logic [W-1:0] eout = '0;
   logic [W-1:0] q[$];

   mean_restore #(.DATA_WIDTH(W), .ALIGN_DELAY(AD)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .mean_in(mean_in), .mean_load(mean_load), .restore_out(restore_out),
      .restore_valid(restore_valid), .sat_flag(sat_flag), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   function automatic logic [W-1:0] restore(input logic [W-1:0] d, input logic [W-1:0] m);
      int s;
      logic [W-1:0] o;
      s = int'($signed(d)) + int'($signed(m));
      o = s[W-1:0];
`ifdef SATURATE_EN
      if (s > 32767) begin o = 16'h7FFF; esat = 1; end
      else if (s < -32768) begin o = 16'h8000; esat = 1; end
`endif
      return o;
   endfunction

   task automatic cyc(input bit r, input bit dv, input logic [W-1:0] d, input bit ml, input logic [W-1:0] m);
      logic [W-1:0] mm;
      reset = r; data_valid = dv; data_in = d; mean_load = ml; mean_in = m;
      ev = 0;
      if (r) begin
         have = 0; pv = 0; drops = 0; esat = 0; eout = '0; act = '0; pend = '0;
         q.delete();
      end else begin
         if (dv) begin
            if (!have) drops = (drops == 255) ? 255 : drops + 1;
            else begin
               mm = (pv && rem == 0) ? pend : act;
               eout = restore(d, mm);
               q.push_back(eout);
               ev = 1;
               if (pv && !ml) begin
                  if (rem == 0) begin act = pend; pv = 0; end
                  else rem--;
               end
            end
         end
         if (ml) begin
            if (!have) begin act = m; have = 1; end
            else begin pend = m; pv = 1; rem = AD; end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(0, 0, '0, 0, '0);
   endtask

   // Monitor: samples one time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      chk("restore_valid", {31'd0, restore_valid}, {31'd0, ev});
      if (restore_valid) begin
         if (q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
         else chk("restore_out", {16'd0, restore_out}, {16'd0, q.pop_front()});
      end else
         chk("restore_hold", {16'd0, restore_out}, {16'd0, eout});
      chk("drop_count", {24'd0, drop_count}, drops);
      chk("sat_flag", {31'd0, sat_flag}, {31'd0, esat});
   end

   initial begin
      @(negedge clk);
      cyc(1, 0, '0, 0, '0);
      // No mean yet: samples dropped, reset clears the count.
      repeat (3) cyc(0, 1, 16'h1234, 0, '0);
      chk("drop3", {24'd0, drop_count}, 32'd3);
      cyc(1, 1, 16'h1111, 0, '0);
      chk("drop_reset", {24'd0, drop_count}, 32'd0);
      // First mean then one sample.
      cyc(0, 0, '0, 1, 16'h0100);
      cyc(0, 1, 16'hFFF0, 0, '0);
      chk("first_sample", {16'd0, restore_out}, 32'h00F0);
      idle();
      // Aligned mean change.
      cyc(0, 0, '0, 1, 16'h0200);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 16'h0000, 0, '0);
         chk("align", {16'd0, restore_out}, (i < AD) ? 32'h0100 : 32'h0200);
      end
      // Restarted alignment.
      cyc(0, 0, '0, 1, 16'h0300);
      for (int i = 0; i < 12; i++) begin
         cyc(0, 1, 16'h0000, i == 3, 16'h0400);
      end
      // Overflow boundaries.
      cyc(1, 0, '0, 0, '0);
      cyc(0, 0, '0, 1, 16'h7F00);
      cyc(0, 1, 16'h0200, 0, '0);
`ifdef SATURATE_EN
      chk("pos_ovf", {16'd0, restore_out}, 32'h7FFF);
      chk("pos_ovf_flag", {31'd0, sat_flag}, 32'd1);
`else
      chk("pos_wrap", {16'd0, restore_out}, 32'h8100);
      chk("pos_wrap_flag", {31'd0, sat_flag}, 32'd0);
`endif
      cyc(1, 0, '0, 0, '0);
      cyc(0, 0, '0, 1, 16'h8000);
      cyc(0, 1, 16'hFFFF, 0, '0);
`ifdef SATURATE_EN
      chk("neg_ovf", {16'd0, restore_out}, 32'h8000);
`else
      chk("neg_wrap", {16'd0, restore_out}, 32'h7FFF);
`endif
      // Reset while pending, then the next sample is dropped.
      cyc(0, 0, '0, 1, 16'h0055);
      cyc(0, 1, 16'h0001, 0, '0);
      cyc(1, 0, '0, 0, '0);
      chk("rst_pending_out", {16'd0, restore_out}, 32'h0);
      cyc(0, 1, 16'h0001, 0, '0);
      chk("drop_after_rst", {24'd0, drop_count}, 32'd1);
      // Same-cycle load and sample in RUN, and leaving IDLE.
      cyc(0, 1, 16'h0002, 1, 16'h0010);
      cyc(0, 1, 16'h0001, 1, 16'h0020);
      chk("same_cycle", {16'd0, restore_out}, 32'h0011);
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [W-1:0] d, m;
         d = W'($urandom);
         m = W'($urandom);
         if ($urandom_range(3) == 0) d = {{8{d[7]}}, d[7:0]};
         cyc($urandom_range(99) == 0, $urandom_range(3) != 0, d,
             $urandom_range(19) == 0, m);
      end
      repeat (300) cyc(0, 1, 16'h0001, 0, '0);
      idle();
      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
